// File: rtl/shift_cmd_seq_if.sv
// shift_cmd_seq_if: valid/ready command channel into the shift command sequencer.
interface shift_cmd_seq_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [CNT_W-1:0]  cmd_count;
  modport master(output cmd_valid, cmd_op, cmd_data, cmd_count, input cmd_ready);
  modport slave(input cmd_valid, cmd_op, cmd_data, cmd_count, output cmd_ready);
endinterface

// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq: expands one command into per-cycle enable/direction/data controls for the shift register.
module shift_cmd_seq #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  shift_cmd_seq_if.slave    c,
  input  logic              hold,
  output logic              enable,
  output logic [1:0]        shift_direction,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] OP_SERIAL = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b11;
  state_t            state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  rem_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      data_q <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        IDLE: if (c.cmd_valid) begin
          op_q   <= c.cmd_op;
          data_q <= c.cmd_data;
          rem_q  <= (c.cmd_op == OP_LOAD) ? CNT_W'(1) : c.cmd_count;
          state  <= (c.cmd_op != OP_LOAD && c.cmd_count == '0) ? DONE : RUN;
        end
        RUN: if (!hold) begin
          rem_q <= rem_q - 1'b1;
          if (op_q == OP_SERIAL) data_q <= data_q >> 1;
          if (rem_q == CNT_W'(1)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Outputs decode only from registered state plus hold, never from cmd_*.
  always_comb begin
    c.cmd_ready     = (state == IDLE) && !reset;
    enable          = (state == RUN) && !hold;
    shift_direction = (state == RUN) ? op_q : OP_SERIAL;
    data_in         = (state != RUN) ? '0 :
                      (op_q == OP_LOAD) ? data_q :
                      (op_q == OP_SERIAL) ? {{(DATA_W-1){1'b0}}, data_q[0]} : '0;
    busy            = (state != IDLE);
    done            = (state == DONE);
  end
endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb_shift_cmd_seq: per-cycle comparison against a command-level model, plus directed literal checks.
module tb_shift_cmd_seq;
  logic       clk = 0;
  logic       reset;
  logic       hold;
  logic       enable, busy, done;
  logic [1:0] shift_direction;
  logic [7:0] data_in;
  shift_cmd_seq_if #(.DATA_W(8), .CNT_W(4)) c();
  shift_cmd_seq #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .c(c.slave), .hold(hold), .enable(enable),
    .shift_direction(shift_direction), .data_in(data_in), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic       chk_on = 0;
  logic       e_rdy, e_en, e_busy, e_done;
  logic [1:0] e_dir;
  logic [7:0] e_din;
  int         en_cnt, done_cyc, t0;
  logic [15:0] bits;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) if (chk_on) begin
    chk("cmd_ready", 32'(c.cmd_ready), 32'(e_rdy));
    chk("enable", 32'(enable), 32'(e_en));
    chk("shift_direction", 32'(shift_direction), 32'(e_dir));
    chk("data_in", 32'(data_in), 32'(e_din));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
  end
  always @(negedge clk) if (!reset) begin
    if (enable) begin
      if (en_cnt < 16) bits[en_cnt] = data_in[0];
      en_cnt++;
    end
    if (done) done_cyc = cyc;
  end
  task automatic tick; @(posedge clk); #1; endtask
  task automatic set_exp(input logic r, input logic en, input logic [1:0] d, input logic [7:0] di,
                         input logic b, input logic dn);
    e_rdy = r; e_en = en; e_dir = d; e_din = di; e_busy = b; e_done = dn;
  endtask
  task automatic junk_cmd(input logic v);
    c.cmd_valid = v; c.cmd_op = 2'($urandom); c.cmd_data = 8'($urandom); c.cmd_count = 4'($urandom);
  endtask
  // Expected data_in for the k-th issued step: LOAD word, k-th serial bit (zero past the width), else 0.
  function automatic logic [7:0] exp_din(input logic [1:0] op, input logic [7:0] d, input int k);
    if (op == 2'b11) return d;
    if (op == 2'b01) return (k < 8) ? {7'd0, d[k]} : 8'd0;
    return 8'd0;
  endfunction
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [3:0] cnt,
                         input bit rnd, input logic [15:0] hpat, input int abort_at);
    int n, k, j;
    logic h;
    c.cmd_valid = 1; c.cmd_op = op; c.cmd_data = d; c.cmd_count = cnt;
    hold = 1'($urandom);
    set_exp(1, 0, 2'b01, 8'd0, 0, 0);
    tick;
    t0 = cyc - 1; en_cnt = 0; done_cyc = -1; bits = '0;
    n = (op == 2'b11) ? 1 : int'(cnt);
    k = 0; j = 0;
    while (k < n) begin
      if (k == abort_at) begin
        reset = 1; hold = 0; c.cmd_valid = 0;
        set_exp(0, 0, 2'b01, 8'd0, 0, 0);
        tick; tick;
        reset = 0;
        set_exp(1, 0, 2'b01, 8'd0, 0, 0);
        return;
      end
      h = rnd ? ($urandom_range(0, 3) == 0 && j < 40) : (j < 16 && hpat[j]);
      junk_cmd(1'($urandom));
      hold = h;
      set_exp(0, !h, op, exp_din(op, d, k), 1, 0);
      tick;
      if (!h) k++;
      j++;
    end
    junk_cmd(1);
    hold = 1'($urandom);
    set_exp(0, 0, 2'b01, 8'd0, 1, 1);
    tick;
    c.cmd_valid = 0; hold = 0;
    set_exp(1, 0, 2'b01, 8'd0, 0, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1; hold = 0; c.cmd_valid = 0; c.cmd_op = 0; c.cmd_data = 0; c.cmd_count = 0;
    en_cnt = 0; done_cyc = -1; bits = '0;
    set_exp(0, 0, 2'b01, 8'd0, 0, 0);
    chk_on = 1;
    tick; tick;
    reset = 0;
    set_exp(1, 0, 2'b01, 8'd0, 0, 0);
    tick;
    run_cmd(2'b11, 8'hA5, 4'd7, 0, 16'h0, -1);
    chk("load_enables", 32'(en_cnt), 32'd1);
    chk("load_done_off", 32'(done_cyc - t0), 32'd2);
    tick;
    run_cmd(2'b00, 8'hFF, 4'd3, 0, 16'h0, -1);
    chk("shl_enables", 32'(en_cnt), 32'd3);
    chk("shl_done_off", 32'(done_cyc - t0), 32'd4);
    run_cmd(2'b01, 8'hB2, 4'd4, 0, 16'h0, -1);
    chk("serial_bits", 32'(bits[3:0]), 32'h2);
    chk("serial_enables", 32'(en_cnt), 32'd4);
    run_cmd(2'b10, 8'h5A, 4'd4, 0, 16'h0006, -1);
    chk("shr_hold_enables", 32'(en_cnt), 32'd4);
    chk("shr_hold_done_off", 32'(done_cyc - t0), 32'd7);
    run_cmd(2'b10, 8'h3C, 4'd0, 0, 16'h0, -1);
    chk("zero_enables", 32'(en_cnt), 32'd0);
    chk("zero_done_off", 32'(done_cyc - t0), 32'd1);
    tick;
    run_cmd(2'b01, 8'hFF, 4'd11, 0, 16'h0, -1);
    chk("serial_long_bits", 32'(bits[10:0]), 32'h0FF);
    run_cmd(2'b00, 8'h00, 4'd10, 0, 16'h0, 3);
    chk("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    chk("abort_enables", 32'(en_cnt), 32'd3);
    run_cmd(2'b11, 8'h3C, 4'd0, 0, 16'h0, -1);
    chk("post_abort_load_done_off", 32'(done_cyc - t0), 32'd2);
    for (int i = 0; i < 200; i++) begin
      logic [1:0] op;
      logic [3:0] cnt;
      op = 2'($urandom); cnt = 4'($urandom);
      run_cmd(op, 8'($urandom), cnt, 1, 16'h0, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        hold = 1'($urandom);
        tick;
      end
    end
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
